// File: rtl/plic_claim_agent.sv
// PLIC claim/complete agent for one interrupt context: claims via a bus read, hands the ID to a consumer, completes via a bus write.
// Optional bus watchdog under `PLIC_CLAIM_AGENT_TIMEOUT_EN. Bus ports are the packed reg_intf layouts:
// req_o = {addr[31:0], write, wdata[31:0], wstrb[3:0], valid}, resp_i = {rdata[31:0], error, ready}.
module plic_claim_agent #(
  parameter int unsigned N_SOURCE       = 128,
  parameter int unsigned SRCW           = $clog2(N_SOURCE + 1),
  parameter int unsigned TARGET_ID      = 0,
  parameter logic [31:0] PLIC_BASE      = 32'h0C00_0000,
  parameter logic [31:0] CC_OFFSET      = 32'h0020_0004,
  parameter logic [31:0] CTX_STRIDE     = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            eip_i,
  output logic [69:0]     req_o,
  input  logic [33:0]     resp_i,
  output logic            irq_valid_o,
  output logic [SRCW-1:0] irq_id_o,
  input  logic            irq_ready_i,
  input  logic            done_i,
  output logic            busy_o,
  output logic            err_o,
  output logic [15:0]     spurious_cnt_o
);

  localparam logic [31:0] CC_ADDR = PLIC_BASE + CC_OFFSET + TARGET_ID * CTX_STRIDE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLAIM,
    S_DISPATCH,
    S_SERVICE,
    S_COMPLETE
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SRCW-1:0] r_id;
  logic            r_err;
  logic [15:0]     r_spur;
  logic            w_err_set;
  logic            w_spur_inc;
  logic            w_id_load;
  logic            w_bus;
  logic            w_rdy;
  logic            w_rerr;
  logic [SRCW-1:0] w_rid;
  logic            w_tmo_hit;
  logic            w_unused_rdata;

  assign w_rdy          = resp_i[0];
  assign w_rerr         = resp_i[1];
  assign w_rid          = resp_i[2 +: SRCW];
  assign w_unused_rdata = ^resp_i[33:2+SRCW];
  assign w_bus          = (r_state == S_CLAIM) || (r_state == S_COMPLETE);

`ifdef PLIC_CLAIM_AGENT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  // Counts cycles spent waiting on the bus; restarts on every state change or ready.
  always_ff @(posedge clk_i) begin
    if (rst_i || !w_bus || w_rdy || (w_state_nxt != r_state)) r_tmo <= '0;
    else                                                      r_tmo <= r_tmo + 1'b1;
  end
  assign w_tmo_hit = w_bus && !w_rdy && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_err   <= 1'b0;
      r_spur  <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_id_load)  r_id   <= w_rid;
      if (w_err_set)  r_err  <= 1'b1;
      if (w_spur_inc) r_spur <= sat_inc(r_spur);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    w_spur_inc  = 1'b0;
    w_id_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (eip_i && enable_i && !r_err) w_state_nxt = S_CLAIM;
      end
      S_CLAIM: begin
        if (w_rdy) begin
          w_state_nxt = S_IDLE;
          if (w_rerr)                          w_err_set  = 1'b1;
          else if (w_rid == '0)                w_spur_inc = 1'b1;
          else if (32'(w_rid) > N_SOURCE)      w_err_set  = 1'b1;
          else begin
            w_id_load   = 1'b1;
            w_state_nxt = S_DISPATCH;
          end
        end else if (w_tmo_hit) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DISPATCH: begin
        if (irq_ready_i) w_state_nxt = S_SERVICE;
      end
      S_SERVICE: begin
        if (done_i) w_state_nxt = S_COMPLETE;
      end
      S_COMPLETE: begin
        if (w_rdy) begin
          w_err_set   = w_rerr;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request fields are pure functions of state, so they stay stable until ready moves the FSM.
  assign req_o = {
    (w_bus ? CC_ADDR : 32'h0),
    (r_state == S_COMPLETE),
    ((r_state == S_COMPLETE) ? 32'(r_id) : 32'h0),
    ((r_state == S_COMPLETE) ? 4'hF : 4'h0),
    w_bus
  };

  assign irq_valid_o    = (r_state == S_DISPATCH);
  assign irq_id_o       = r_id;
  assign busy_o         = (r_state != S_IDLE);
  assign err_o          = r_err;
  assign spurious_cnt_o = r_spur;

endmodule
